wbu_regfile: RTL and testbench

//  Write-back stage directly downstream of the load/store stage. Accepts one 104-bit packet
//  per valid/ready handshake, selects the ALU result or the load data, and commits it to the

---
 rtl/wbu_regfile.sv | 144 ++++++++++++++
 tb/tb_wbu_regfile.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wbu_regfile.sv
// rtl/wbu_regfile.sv - write-back stage: one-entry pending register, GPR file with bypassed
// read ports, retire pulse/counter and ebreak halt.
module wbu_regfile #(
  parameter int WIDTH   = 32,
  parameter int NR_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_valid,
  input  logic [103:0]     lsu_data,
  output logic             wbu_ready,
  input  logic [4:0]       rs1_addr,
  output logic [WIDTH-1:0] rs1_data,
  input  logic [4:0]       rs2_addr,
  output logic [WIDTH-1:0] rs2_data,
  output logic             wbu_valid,
  output logic [31:0]      commit_pc,
  output logic [63:0]      retire_cnt,
  output logic             halt,
  output logic [WIDTH-1:0] halt_code
);

  localparam int         AW        = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;
  localparam logic [5:0] NR_REGS_L = 6'(NR_REGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    HALT   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             pend_wen_q, pend_wen_d;
  logic             pend_ebreak_q, pend_ebreak_d;
  logic [WIDTH-1:0] pend_wdata_q, pend_wdata_d;
  logic [63:0]      retire_cnt_q, retire_cnt_d;
  logic [WIDTH-1:0] gpr_q [NR_REGS];
  logic [WIDTH-1:0] gpr_d [NR_REGS];

  logic accept;
  logic committing;
  logic wr_en;

  assign committing = (state_q == COMMIT);
  // An ebreak in flight blocks new packets so nothing slips past the halt.
  assign wbu_ready  = (state_q != HALT) && !(committing && pend_ebreak_q);
  assign accept     = lsu_valid && wbu_ready;
  assign wr_en      = committing && pend_wen_q && (pend_rd_q != 5'd0)
                      && ({1'b0, pend_rd_q} < NR_REGS_L);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = COMMIT;
      COMMIT: begin
        if (pend_ebreak_q)  state_d = HALT;
        else if (accept)    state_d = COMMIT;
        else                state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Write data is selected at accept time so the commit cycle only carries one word.
  always_comb begin
    pend_pc_d     = pend_pc_q;
    pend_rd_d     = pend_rd_q;
    pend_wen_d    = pend_wen_q;
    pend_ebreak_d = pend_ebreak_q;
    pend_wdata_d  = pend_wdata_q;
    if (accept) begin
      pend_pc_d     = lsu_data[39:8];
      pend_rd_d     = lsu_data[7:3];
      pend_wen_d    = lsu_data[2];
      pend_ebreak_d = lsu_data[0];
      pend_wdata_d  = WIDTH'(lsu_data[1] ? lsu_data[71:40] : lsu_data[103:72]);
    end
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q + {63'd0, committing};
  end

  always_comb begin
    gpr_d = gpr_q;
    if (wr_en) gpr_d[pend_rd_q[AW-1:0]] = pend_wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pend_pc_q     <= '0;
      pend_rd_q     <= '0;
      pend_wen_q    <= 1'b0;
      pend_ebreak_q <= 1'b0;
      pend_wdata_q  <= '0;
      retire_cnt_q  <= '0;
      for (int i = 0; i < NR_REGS; i++) gpr_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pend_pc_q     <= pend_pc_d;
      pend_rd_q     <= pend_rd_d;
      pend_wen_q    <= pend_wen_d;
      pend_ebreak_q <= pend_ebreak_d;
      pend_wdata_q  <= pend_wdata_d;
      retire_cnt_q  <= retire_cnt_d;
      gpr_q         <= gpr_d;
    end
  end

  // Same-index reads see the word retiring this cycle rather than the stale file entry.
  always_comb begin
    rs1_data = '0;
    if ((rs1_addr != 5'd0) && ({1'b0, rs1_addr} < NR_REGS_L)) begin
      if (wr_en && (pend_rd_q == rs1_addr)) rs1_data = pend_wdata_q;
      else                                  rs1_data = gpr_q[rs1_addr[AW-1:0]];
    end
  end

  always_comb begin
    rs2_data = '0;
    if ((rs2_addr != 5'd0) && ({1'b0, rs2_addr} < NR_REGS_L)) begin
      if (wr_en && (pend_rd_q == rs2_addr)) rs2_data = pend_wdata_q;
      else                                  rs2_data = gpr_q[rs2_addr[AW-1:0]];
    end
  end

  generate
    if (NR_REGS > 10) begin : g_a0
      assign halt_code = gpr_q[10];
    end else begin : g_no_a0
      assign halt_code = '0;
    end
  endgenerate

  assign wbu_valid  = committing;
  assign commit_pc  = pend_pc_q;
  assign retire_cnt = retire_cnt_q;
  assign halt       = (state_q == HALT);

endmodule

// File: tb/tb_wbu_regfile.sv
// tb/tb_wbu_regfile.sv - scoreboard bench for wbu_regfile (NR_REGS=16) against an
// architectural-state reference model.
module tb_wbu_regfile;

  localparam int NREGS = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lsu_valid = 1'b0;
  logic [103:0] lsu_data = '0;
  logic         wbu_ready;
  logic [4:0]   rs1_addr = '0;
  logic [31:0]  rs1_data;
  logic [4:0]   rs2_addr = '0;
  logic [31:0]  rs2_data;
  logic         wbu_valid;
  logic [31:0]  commit_pc;
  logic [63:0]  retire_cnt;
  logic         halt;
  logic [31:0]  halt_code;

  wbu_regfile #(.WIDTH(32), .NR_REGS(NREGS)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_data(lsu_data),
    .wbu_ready(wbu_ready), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .wbu_valid(wbu_valid),
    .commit_pc(commit_pc), .retire_cnt(retire_cnt), .halt(halt), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  logic [103:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [31:0]  model [NREGS];
  longint       retired = 0;
  bit           halted = 1'b0;
  logic [4:0]   last_rd = '0;

  function automatic logic [103:0] mk(input logic [31:0] alu, input logic [31:0] ld,
                                      input logic [31:0] pc, input logic [4:0] rd,
                                      input logic wen, input logic sel, input logic eb);
    return {alu, ld, pc, rd, wen, sel, eb};
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= NREGS) return 32'd0;
    return model[a[3:0]];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the model holds architectural state including the packet retiring this cycle.
  initial begin
    logic [103:0] p;
    bit           retiring;
    bit           cur_eb;
    logic [31:0]  wd;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        retired = 0;
        halted  = 1'b0;
        chk("rst_ready", {63'd0, wbu_ready}, 64'd1);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_valid", {63'd0, wbu_valid}, 64'd0);
        chk("rst_retire_cnt", retire_cnt, 64'd0);
        chk("rst_commit_pc", {32'd0, commit_pc}, 64'd0);
        chk("rst_rs1_data", {32'd0, rs1_data}, 64'd0);
      end else begin
        retiring = (exp_q.size() > 0);
        cur_eb   = 1'b0;
        chk("wbu_valid", {63'd0, wbu_valid}, {63'd0, retiring});
        if (retiring) begin
          p = exp_q.pop_front();
          chk("commit_pc", {32'd0, commit_pc}, {32'd0, p[39:8]});
          wd = p[1] ? p[71:40] : p[103:72];
          if (p[2] && p[7:3] != 5'd0 && int'(p[7:3]) < NREGS) model[p[6:3]] = wd;
          cur_eb = p[0];
        end
        chk("retire_cnt", retire_cnt, 64'(retired));
        chk("halt", {63'd0, halt}, {63'd0, halted});
        chk("wbu_ready", {63'd0, wbu_ready}, {63'd0, !halted && !cur_eb});
        chk("rs1_data", {32'd0, rs1_data}, {32'd0, mread(rs1_addr)});
        chk("rs2_data", {32'd0, rs2_data}, {32'd0, mread(rs2_addr)});
        if (halted) chk("halt_code", {32'd0, halt_code}, {32'd0, model[10]});
        if (retiring) retired++;
        if (cur_eb) halted = 1'b1;
      end
    end
  end

  task automatic drive(input logic v, input logic [103:0] d,
                       input logic [4:0] a1, input logic [4:0] a2);
    bit acc;
    lsu_valid = v;
    lsu_data  = d;
    rs1_addr  = a1;
    rs2_addr  = a2;
    @(negedge clk);
    acc = v && wbu_ready && !rst;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(d);
      last_rd = d[7:3];
    end
    #1;
  endtask

  task automatic do_reset();
    lsu_valid = 1'b0;
    rs1_addr  = 5'd5;
    rs2_addr  = 5'd5;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_phase(input int n, inout logic [31:0] pc);
    logic [103:0] d;
    logic [4:0]   a2;
    for (int i = 0; i < n; i++) begin
      d  = mk($urandom, $urandom, pc, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      a2 = ($urandom_range(0, 1) == 1) ? last_rd : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), d, 5'($urandom_range(0, 31)), a2);
      pc += 32'd4;
    end
  endtask

  initial begin
    logic [31:0] pc;
    pc = 32'h1000;
    do_reset();

    drive(1'b1, mk(32'h1234, 32'h0, 32'h100, 5'd5, 1'b1, 1'b0, 1'b0), 5'd0, 5'd0);
    drive(1'b0, '0, 5'd5, 5'd0);
    drive(1'b0, '0, 5'd5, 5'd0);

    drive(1'b1, mk(32'h0, 32'hFFFF_FF80, 32'h104, 5'd7, 1'b1, 1'b1, 1'b0), 5'd0, 5'd0);
    drive(1'b0, '0, 5'd0, 5'd7);
    drive(1'b0, '0, 5'd7, 5'd7);

    drive(1'b1, mk(32'hDEAD, 32'h0, 32'h108, 5'd0, 1'b1, 1'b0, 1'b0), 5'd0, 5'd0);
    drive(1'b1, mk(32'hBEEF, 32'h0, 32'h10C, 5'd20, 1'b1, 1'b0, 1'b0), 5'd0, 5'd20);
    drive(1'b0, '0, 5'd20, 5'd4);

    for (int k = 0; k < 4; k++)
      drive(1'b1, mk(32'hA0 + 32'(k), 32'h0, 32'h200 + 32'(4 * k), 5'(k + 1), 1'b1, 1'b0, 1'b0),
            5'(k), 5'(k + 1));
    drive(1'b0, '0, 5'd4, 5'd3);

    rand_phase(300, pc);

    drive(1'b1, mk(32'h5555, 32'h0, 32'h300, 5'd3, 1'b1, 1'b0, 1'b0), 5'd3, 5'd3);
    do_reset();
    drive(1'b0, '0, 5'd3, 5'd5);

    rand_phase(100, pc);

    drive(1'b1, mk(32'hABCD, 32'h0, 32'h400, 5'd10, 1'b1, 1'b0, 1'b1), 5'd10, 5'd10);
    for (int k = 0; k < 8; k++)
      drive(1'b1, mk($urandom, $urandom, 32'h500, 5'd10, 1'b1, 1'b0, 1'b0), 5'd10, 5'd10);

    do_reset();
    drive(1'b1, mk(32'h0, 32'h0, 32'h600, 5'd10, 1'b1, 1'b0, 1'b0), 5'd0, 5'd0);
    drive(1'b1, mk(32'h0, 32'h0, 32'h604, 5'd0, 1'b0, 1'b0, 1'b1), 5'd10, 5'd0);
    for (int k = 0; k < 8; k++)
      drive(1'b1, mk($urandom, $urandom, 32'h700, 5'd9, 1'b1, 1'b1, 1'b0), 5'd10, 5'd9);

    lsu_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
